// File: rtl/edge_evt_pkg.sv
// Shared encodings for the edge event arbiter: channel mode codes and the
// offer FSM state type.
package edge_evt_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/edge_chan.sv
// One input channel: edge detection under the selected mode, a single pending
// event slot with its edge type, and a sticky overflow flag.
module edge_chan
  import edge_evt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       consume,
  input  logic       ovf_clr,
  output logic       pending,
  output logic       type_q,
  output logic       overflow
);

  logic prev_q;
  logic armed_q;
  logic want_rise;
  logic want_fall;
  logic qual;
  logic ovf_set;

  assign want_rise = (mode == MODE_RISE) || (mode == MODE_BOTH);
  assign want_fall = (mode == MODE_FALL) || (mode == MODE_BOTH);

  // armed_q masks the first sample after reset so the reset level of prev_q
  // never shows up as an edge.
  assign qual    = armed_q & (sig ^ prev_q) & ((sig & want_rise) | (~sig & want_fall));
  assign ovf_set = qual & pending & ~consume;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
      pending  <= 1'b0;
      type_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev_q  <= sig;
      armed_q <= 1'b1;

      if (mode == MODE_OFF) begin
        pending <= 1'b0;
      end else if (qual && (!pending || consume)) begin
        pending <= 1'b1;
        type_q  <= sig;
      end else if (consume) begin
        pending <= 1'b0;
      end

      // A fresh overflow beats a simultaneous clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// N-channel edge event controller: per-channel detectors feeding a round-robin
// picker and a single valid/ready event port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   sig_in,
  input  logic [2*N-1:0] edge_mode,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_ch,
  output logic           evt_rise,
  output logic [N-1:0]   overflow,
  input  logic           ovf_clr
);

  logic [N-1:0]   pending;
  logic [N-1:0]   type_q;
  logic [N-1:0]   consume;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  state_t         state;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign consume[i] = evt_valid & evt_ready & (evt_ch == IDW'(i));

    edge_chan u_chan (
      .clk      (clk),
      .rst      (rst),
      .sig      (sig_in[i]),
      .mode     (edge_mode[2*i +: 2]),
      .consume  (consume[i]),
      .ovf_clr  (ovf_clr),
      .pending  (pending[i]),
      .type_q   (type_q[i]),
      .overflow (overflow[i])
    );
  end

  // Rotate pending so bit 0 is the channel right after the last grant; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  assign start = (last_grant == IDW'(N - 1)) ? '0 : last_grant + 1'b1;
  assign dbl   = {pending, pending} >> start;
  assign rot   = dbl[N-1:0];

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int off;
    int sum;
    off        = 0;
    pick_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick_found = 1'b1;
        off        = k;
      end
    end
    sum = int'(start) + off;
    if (sum >= N) sum = sum - N;
    pick_idx = IDW'(sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      evt_valid  <= 1'b0;
      evt_ch     <= '0;
      evt_rise   <= 1'b0;
      last_grant <= IDW'(N - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            evt_ch    <= pick_idx;
            evt_rise  <= type_q[pick_idx];
            evt_valid <= 1'b1;
            state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (evt_ready) begin
            last_grant <= evt_ch;
            evt_valid  <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4): a vector table of per-cycle
// inputs and expected outputs, plus hand sequences for multi-cycle corners.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   sig_in;
  logic [2*N-1:0] edge_mode;
  logic           evt_valid;
  logic           evt_ready;
  logic [1:0]     evt_ch;
  logic           evt_rise;
  logic [N-1:0]   overflow;
  logic           ovf_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] sig;
    logic [7:0] mode;
    logic       rdy;
    logic       clr;
    logic       valid;
    logic [1:0] ch;
    logic       rise;
    logic [3:0] ovf;
  } vec_t;

  vec_t vecs[$];

  edge_event_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .edge_mode (edge_mode),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(logic r, logic [3:0] s, logic [7:0] m, logic rdy, logic clr,
                             logic val, logic [1:0] ch, logic rise, logic [3:0] ovf);
    vec_t t;
    t.rst = r; t.sig = s; t.mode = m; t.rdy = rdy; t.clr = clr;
    t.valid = val; t.ch = ch; t.rise = rise; t.ovf = ovf;
    return t;
  endfunction

  initial begin
    // No event from reset level; ch2 falls and is offered two edges later.
    vecs.push_back(v(1, 4'b1111, 8'hFF, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1111, 8'hFF, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'hFF, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'hFF, 0, 0, 1, 2, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'hFF, 1, 0, 0, 0, 0, 4'b0000));
    // Reset, then channels 0,1,3 rise together: round-robin ch0, ch1, ch3.
    vecs.push_back(v(0, 4'b0000, 8'h55, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b0000, 8'h55, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h55, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h55, 1, 0, 1, 0, 1, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h55, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h55, 1, 0, 1, 1, 1, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h55, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h55, 1, 0, 1, 3, 1, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h55, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h55, 1, 0, 0, 0, 0, 4'b0000));
    // Ch1 fall-only: the rise is ignored, the fall is reported.
    vecs.push_back(v(1, 4'b1001, 8'h00, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1001, 8'h08, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1011, 8'h08, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1001, 8'h08, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1001, 8'h08, 1, 0, 1, 1, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1001, 8'h08, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1001, 8'h08, 1, 0, 0, 0, 0, 4'b0000));
    // Consumer stalled, ch0 toggles twice: first edge kept, overflow, then clear.
    vecs.push_back(v(1, 4'b1001, 8'h03, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1000, 8'h03, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1001, 8'h03, 0, 0, 1, 0, 0, 4'b0001));
    vecs.push_back(v(1, 4'b1001, 8'h03, 0, 0, 1, 0, 0, 4'b0001));
    vecs.push_back(v(1, 4'b1001, 8'h03, 0, 1, 1, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1001, 8'h03, 1, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(v(1, 4'b1001, 8'h03, 0, 0, 0, 0, 0, 4'b0000));

    rst       = 1'b0;
    sig_in    = 4'b1111;
    edge_mode = 8'hFF;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    step();
    step();
    check("reset_valid", 32'(evt_valid), 32'd0);
    check("reset_ch",    32'(evt_ch),    32'd0);
    check("reset_rise",  32'(evt_rise),  32'd0);
    check("reset_ovf",   32'(overflow),  32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      sig_in    = vecs[i].sig;
      edge_mode = vecs[i].mode;
      evt_ready = vecs[i].rdy;
      ovf_clr   = vecs[i].clr;
      step();
      check($sformatf("v%0d_valid", i), 32'(evt_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("v%0d_ch", i),   32'(evt_ch),   32'(vecs[i].ch));
        check($sformatf("v%0d_rise", i), 32'(evt_rise), 32'(vecs[i].rise));
      end
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end

    // Ch0 edge on the handshake cycle of its own event: re-offered, no overflow.
    sig_in = 4'b1000;
    step();
    check("hs_pend_valid", 32'(evt_valid), 32'd0);
    step();
    check("hs_first_valid", 32'(evt_valid), 32'd1);
    check("hs_first_rise",  32'(evt_rise),  32'd0);
    evt_ready = 1'b1;
    sig_in    = 4'b1001;
    step();
    check("hs_done_valid", 32'(evt_valid), 32'd0);
    check("hs_done_ovf",   32'(overflow),  32'd0);
    step();
    check("hs_second_valid", 32'(evt_valid), 32'd1);
    check("hs_second_ch",    32'(evt_ch),    32'd0);
    check("hs_second_rise",  32'(evt_rise),  32'd1);
    check("hs_second_ovf",   32'(overflow),  32'd0);
    step();
    check("hs_second_done", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Reset asserted mid-offer drops evt_valid without a clock edge.
    sig_in = 4'b1000;
    step();
    step();
    check("rst_mid_offer_valid", 32'(evt_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_valid", 32'(evt_valid), 32'd0);
    check("rst_async_ch",    32'(evt_ch),    32'd0);
    check("rst_async_ovf",   32'(overflow),  32'd0);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst_release_%0d", k), 32'(evt_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
